// File: rtl/sdram_aref_sched.sv
// SDRAM auto-refresh scheduler: tracks owed refreshes against the refresh interval and, once
// granted the bus, issues an optional PRECHARGE-ALL followed by a spaced AUTO REFRESH burst.
module sdram_aref_sched #(
  parameter int unsigned T_REFI    = 1500,
  parameter int unsigned T_RP      = 2,
  parameter int unsigned T_RFC     = 7,
  parameter int unsigned MAX_DEBT  = 8,
  parameter int unsigned URGENT_TH = 6,
  parameter int unsigned MAX_BURST = 4,
  parameter bit          PRE_EN    = 1'b1,
  parameter int unsigned ADDR_W    = 13
) (
  input  logic              sclk,
  input  logic              s_rst,
  input  logic              flag_init_end,
  input  logic              ref_en,
  output logic              ref_req,
  output logic              ref_urgent,
  output logic              flag_ref_end,
  output logic              ref_busy,
  output logic [3:0]        ref_debt,
  output logic              ref_overflow,
  output logic [3:0]        aref_cmd,
  output logic [ADDR_W-1:0] sdram_addr
);

  localparam int unsigned CntW    = (T_REFI > 1) ? $clog2(T_REFI) : 1;
  localparam int unsigned WaitMax = (T_RFC > T_RP) ? T_RFC : T_RP;
  localparam int unsigned WaitW   = $clog2(WaitMax + 1);
  localparam int unsigned RpLoad  = (T_RP > 1) ? T_RP - 2 : 0;
  localparam int unsigned RfcLoad = T_RFC - 2;

  localparam logic [3:0] CmdNop  = 4'b0111;
  localparam logic [3:0] CmdPre  = 4'b0010;
  localparam logic [3:0] CmdAref = 4'b0001;

  typedef enum logic [2:0] {
    StIdle,
    StPre,
    StWaitRp,
    StAref,
    StWaitRfc,
    StDone
  } state_e;

  state_e           state_q;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [3:0]       debt_q, debt_d;
  logic             ovf_q, ovf_d;
  logic [3:0]       burst_q;
  logic [3:0]       burst_init;
  logic [WaitW-1:0] wait_q;
  logic [3:0]       cmd_q;
  logic             done_q;
  logic             tick;
  logic             aref_now;
  logic             req;
  logic             grant;

  always_comb begin
    tick     = flag_init_end && (cnt_q == CntW'(T_REFI - 1));
    aref_now = (state_q == StAref);

    cnt_d = cnt_q;
    if (flag_init_end) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
    end

    // A tick landing on an AREF cycle cancels out and leaves the debt untouched.
    debt_d = debt_q;
    ovf_d  = ovf_q;
    if (tick && !aref_now) begin
      if (debt_q == 4'(MAX_DEBT)) begin
        ovf_d = 1'b1;
      end else begin
        debt_d = debt_q + 1'b1;
      end
    end else if (!tick && aref_now) begin
      debt_d = debt_q - 1'b1;
    end

    req        = (state_q == StIdle) && (debt_q != 4'd0) && !done_q;
    grant      = req && ref_en;
    burst_init = (debt_q > 4'(MAX_BURST)) ? 4'(MAX_BURST) : debt_q;
  end

  always_ff @(posedge sclk or posedge s_rst) begin
    if (s_rst) begin
      cnt_q  <= '0;
      debt_q <= 4'd0;
      ovf_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      debt_q <= debt_d;
      ovf_q  <= ovf_d;
    end
  end

  // Command and done pulse are registered alongside the state so they change on the same edge.
  always_ff @(posedge sclk or posedge s_rst) begin
    if (s_rst) begin
      state_q <= StIdle;
      burst_q <= 4'd0;
      wait_q  <= '0;
      cmd_q   <= CmdNop;
      done_q  <= 1'b0;
    end else begin
      cmd_q  <= CmdNop;
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (grant) begin
            burst_q <= burst_init;
            if (PRE_EN) begin
              state_q <= StPre;
              cmd_q   <= CmdPre;
            end else begin
              state_q <= StAref;
              cmd_q   <= CmdAref;
            end
          end
        end
        StPre: begin
          if (T_RP == 1) begin
            state_q <= StAref;
            cmd_q   <= CmdAref;
          end else begin
            state_q <= StWaitRp;
            wait_q  <= WaitW'(RpLoad);
          end
        end
        StWaitRp: begin
          if (wait_q == '0) begin
            state_q <= StAref;
            cmd_q   <= CmdAref;
          end else begin
            wait_q <= wait_q - 1'b1;
          end
        end
        StAref: begin
          burst_q <= burst_q - 1'b1;
          state_q <= StWaitRfc;
          wait_q  <= WaitW'(RfcLoad);
        end
        StWaitRfc: begin
          if (wait_q == '0) begin
            if (burst_q != 4'd0) begin
              state_q <= StAref;
              cmd_q   <= CmdAref;
            end else begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end
          end else begin
            wait_q <= wait_q - 1'b1;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign ref_req      = req;
  assign ref_urgent   = (debt_q >= 4'(URGENT_TH));
  assign flag_ref_end = done_q;
  assign ref_busy     = (state_q != StIdle);
  assign ref_debt     = debt_q;
  assign ref_overflow = ovf_q;
  assign aref_cmd     = cmd_q;
  assign sdram_addr   = ADDR_W'(11'h400);

endmodule

// File: tb/tb_sdram_aref_sched.sv
// Bench for sdram_aref_sched: a default build under directed scenarios and a small PRE_EN=0
// build under random traffic, both tracked cycle by cycle by a timeline-based reference model.
module tb_sdram_aref_sched;

  localparam int A_REFI = 1500, A_RP = 2, A_RFC = 7, A_MAXD = 8, A_URG = 6, A_MAXB = 4;
  localparam int B_REFI = 24, B_RP = 1, B_RFC = 3, B_MAXD = 5, B_URG = 3, B_MAXB = 2;
  localparam logic [3:0] NOP = 4'b0111, PRE = 4'b0010, AREF = 4'b0001;

  logic sclk = 1'b0;
  logic s_rst = 1'b0;
  logic init_a = 1'b0, en_a = 1'b0, init_b = 1'b0, en_b = 1'b0;

  logic        req_a, urg_a, end_a, busy_a, ovf_a;
  logic [3:0]  debt_a, cmd_a;
  logic [12:0] addr_a;
  logic        req_b, urg_b, end_b, busy_b, ovf_b;
  logic [3:0]  debt_b, cmd_b;
  logic [11:0] addr_b;

  sdram_aref_sched u_dut_a (
    .sclk(sclk), .s_rst(s_rst), .flag_init_end(init_a), .ref_en(en_a),
    .ref_req(req_a), .ref_urgent(urg_a), .flag_ref_end(end_a), .ref_busy(busy_a),
    .ref_debt(debt_a), .ref_overflow(ovf_a), .aref_cmd(cmd_a), .sdram_addr(addr_a)
  );

  sdram_aref_sched #(
    .T_REFI(B_REFI), .T_RP(B_RP), .T_RFC(B_RFC), .MAX_DEBT(B_MAXD), .URGENT_TH(B_URG),
    .MAX_BURST(B_MAXB), .PRE_EN(1'b0), .ADDR_W(12)
  ) u_dut_b (
    .sclk(sclk), .s_rst(s_rst), .flag_init_end(init_b), .ref_en(en_b),
    .ref_req(req_b), .ref_urgent(urg_b), .flag_ref_end(end_b), .ref_busy(busy_b),
    .ref_debt(debt_b), .ref_overflow(ovf_b), .aref_cmd(cmd_b), .sdram_addr(addr_b)
  );

  always #5 sclk = ~sclk;

  wire [12:0] vec_a = {req_a, urg_a, end_a, busy_a, debt_a, ovf_a, cmd_a};
  wire [12:0] vec_b = {req_b, urg_b, end_b, busy_b, debt_b, ovf_b, cmd_b};

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int b_en_range = 3;

  int p_refi[2], p_rp[2], p_rfc[2], p_maxd[2], p_urg[2], p_maxb[2], p_pre[2];
  // Model: interval count, debt, sticky overflow, and the active burst as (offset since grant,
  // burst length); commands are placed on that timeline arithmetically.
  int m_cnt[2], m_debt[2], m_ovf[2], m_act[2], m_off[2], m_burst[2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pre_len(int k);
    return (p_pre[k] != 0) ? p_rp[k] : 0;
  endfunction

  function automatic logic [3:0] m_cmd(int k);
    int rel;
    if (m_act[k] == 0) return NOP;
    if (p_pre[k] != 0 && m_off[k] == 1) return PRE;
    if (m_off[k] > pre_len(k)) begin
      rel = m_off[k] - pre_len(k) - 1;
      if ((rel % p_rfc[k]) == 0 && (rel / p_rfc[k]) < m_burst[k]) return AREF;
    end
    return NOP;
  endfunction

  function automatic bit m_done(int k);
    return (m_act[k] != 0) && (m_off[k] == pre_len(k) + m_burst[k] * p_rfc[k] + 1);
  endfunction

  function automatic bit m_req(int k);
    return (m_act[k] == 0) && (m_debt[k] > 0);
  endfunction

  function automatic logic [12:0] m_vec(int k);
    logic [3:0] dv;
    dv = 4'(m_debt[k]);
    return {m_req(k), (m_debt[k] >= p_urg[k]), m_done(k), (m_act[k] != 0), dv,
            (m_ovf[k] != 0), m_cmd(k)};
  endfunction

  task automatic model_reset(int k);
    m_cnt[k] = 0; m_debt[k] = 0; m_ovf[k] = 0; m_act[k] = 0; m_off[k] = 0; m_burst[k] = 0;
  endtask

  task automatic model_step(int k, bit init, bit en);
    logic [3:0] c;
    bit d, r, tick;
    int old;
    c = m_cmd(k); d = m_done(k); r = m_req(k); old = m_debt[k];
    tick = init && (m_cnt[k] == p_refi[k] - 1);
    if (init) m_cnt[k] = tick ? 0 : m_cnt[k] + 1;
    if (tick && c != AREF) begin
      if (m_debt[k] == p_maxd[k]) m_ovf[k] = 1;
      else m_debt[k]++;
    end else if (!tick && c == AREF) begin
      m_debt[k]--;
    end
    if (m_act[k] != 0) begin
      if (d) m_act[k] = 0;
      else m_off[k]++;
    end else if (r && en) begin
      m_act[k] = 1;
      m_off[k] = 1;
      m_burst[k] = (old < p_maxb[k]) ? old : p_maxb[k];
    end
  endtask

  task automatic step();
    @(posedge sclk);
    if (s_rst) begin
      model_reset(0);
      model_reset(1);
    end else begin
      model_step(0, init_a, en_a);
      model_step(1, init_b, en_b);
    end
    #1;
    check("a_cycle", 32'(vec_a), 32'(m_vec(0)));
    check("b_cycle", 32'(vec_b), 32'(m_vec(1)));
    if (m_act[1] != 0 && m_off[1] == 1) check("b_first_cmd_aref", 32'(cmd_b), 32'(AREF));
    cyc++;
    if (cyc % 256 == 0) b_en_range = ($urandom_range(0, 2) == 0) ? 400 : $urandom_range(1, 6);
    init_b = ($urandom_range(0, 15) != 0);
    en_b   = ($urandom_range(0, b_en_range) == 0);
  endtask

  task automatic wait_debt_a(input int target, input int budget, input string tag);
    for (int i = 0; i < budget && debt_a != 4'(target); i++) step();
    check(tag, 32'(debt_a), 32'(target));
  endtask

  initial begin
    int npre, nref, last, gapbad, seen_end, urg_seen;
    p_refi = '{A_REFI, B_REFI}; p_rp = '{A_RP, B_RP}; p_rfc = '{A_RFC, B_RFC};
    p_maxd = '{A_MAXD, B_MAXD}; p_urg = '{A_URG, B_URG}; p_maxb = '{A_MAXB, B_MAXB};
    p_pre = '{1, 0};
    model_reset(0);
    model_reset(1);

    #1 s_rst = 1'b1;
    #2;
    check("rst_a", 32'(vec_a), 32'({9'd0, NOP}));
    check("rst_b", 32'(vec_b), 32'({9'd0, NOP}));
    check("addr_a", 32'(addr_a), 32'h400);
    check("addr_b", 32'(addr_b), 32'h400);
    repeat (3) step();
    s_rst = 1'b0;

    // Interval counter gated by init.
    repeat (5000) step();
    check("gate_req", 32'(req_a), 0);
    check("gate_debt", 32'(debt_a), 0);
    init_a = 1'b1;
    repeat (A_REFI - 1) step();
    check("refi_early_debt", 32'(debt_a), 0);
    step();
    check("refi_debt", 32'(debt_a), 1);
    check("refi_req", 32'(req_a), 1);

    // Single refresh timeline.
    en_a = 1'b1;
    step();
    en_a = 1'b0;
    check("single_pre", 32'(cmd_a), 32'(PRE));
    check("single_req_drop", 32'(req_a), 0);
    step();
    check("single_rp_nop", 32'(cmd_a), 32'(NOP));
    step();
    check("single_aref", 32'(cmd_a), 32'(AREF));
    for (int i = 0; i < A_RFC - 1; i++) begin
      step();
      check("single_rfc_nop", 32'(cmd_a), 32'(NOP));
    end
    step();
    check("single_done", 32'(end_a), 1);
    check("single_debt0", 32'(debt_a), 0);
    step();
    check("single_idle", 32'(busy_a), 0);

    // Burst of MAX_BURST from debt 5.
    wait_debt_a(5, 6 * A_REFI, "burst_debt5");
    check("burst_urg0", 32'(urg_a), 0);
    en_a = 1'b1;
    step();
    en_a = 1'b0;
    npre = 0; nref = 0; last = -1; gapbad = 0; seen_end = 0;
    for (int i = 0; i < 60; i++) begin
      if (cmd_a == PRE) npre++;
      if (cmd_a == AREF) begin
        if (last >= 0 && i - last != A_RFC) gapbad++;
        last = i;
        nref++;
      end
      if (end_a) begin
        seen_end = 1;
        break;
      end
      step();
    end
    check("burst_npre", 32'(npre), 1);
    check("burst_naref", 32'(nref), 4);
    check("burst_gap", 32'(gapbad), 0);
    check("burst_end", 32'(seen_end), 1);
    step();
    check("burst_debt_left", 32'(debt_a), 1);
    check("burst_rereq", 32'(req_a), 1);

    // Saturation, urgency, sticky overflow.
    urg_seen = 0;
    for (int i = 0; i < 9 * A_REFI; i++) begin
      step();
      if (urg_a && urg_seen == 0) begin
        urg_seen = 1;
        check("urg_rise_debt", 32'(debt_a), A_URG);
      end
    end
    check("urg_seen", 32'(urg_seen), 1);
    check("sat_debt", 32'(debt_a), A_MAXD);
    check("sat_ovf", 32'(ovf_a), 1);
    check("sat_urg", 32'(urg_a), 1);
    en_a = 1'b1;
    wait_debt_a(0, 400, "service_debt0");
    en_a = 1'b0;
    repeat (12) step();
    check("ovf_sticky", 32'(ovf_a), 1);

    // Tick coinciding with an AREF cycle at debt 2.
    wait_debt_a(2, 3 * A_REFI, "sim_debt2");
    for (int i = 0; i < A_REFI && m_cnt[0] != A_REFI - 4; i++) step();
    en_a = 1'b1;
    step();
    en_a = 1'b0;
    step();
    step();
    check("sim_aref", 32'(cmd_a), 32'(AREF));
    check("sim_debt_before", 32'(debt_a), 2);
    step();
    check("sim_debt_after", 32'(debt_a), 2);
    repeat (20) step();

    // Async reset while in WAIT_RFC.
    wait_debt_a(1, 2 * A_REFI, "ar_debt1");
    en_a = 1'b1;
    step();
    en_a = 1'b0;
    repeat (3) step();
    check("ar_busy_before", 32'(busy_a), 1);
    #2 s_rst = 1'b1;
    #1;
    check("ar_cmd", 32'(cmd_a), 32'(NOP));
    check("ar_debt", 32'(debt_a), 0);
    check("ar_busy", 32'(busy_a), 0);
    check("ar_ovf", 32'(ovf_a), 0);
    model_reset(0);
    model_reset(1);
    repeat (2) step();
    s_rst = 1'b0;

    // Random traffic on both builds.
    for (int i = 0; i < 4000; i++) begin
      step();
      init_a = ($urandom_range(0, 31) != 0);
      en_a   = ($urandom_range(0, 7) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sdram_aref_sched.md
Name: sdram_aref_sched

Overview:
- Parametrised SDRAM auto-refresh scheduler; successor to the single-shot refresh generator.
- Counts the refresh interval after init and accumulates owed refreshes (debt) while the arbiter is busy.
- On grant, issues an optional PRECHARGE-ALL, then a burst of back-to-back AUTO REFRESH commands with tRP/tRFC spacing.
- Raises an urgency flag when debt approaches its limit. Sits between the SDRAM init block and the command arbiter.

Parameters:
T_REFI, 1500, refresh interval in sclk cycles (>=16)
T_RP, 2, precharge-to-refresh spacing in cycles (>=1)
T_RFC, 7, refresh-to-next-command spacing in cycles (>=2)
MAX_DEBT, 8, saturation limit of owed refreshes (1..15)
URGENT_TH, 6, debt level at which ref_urgent asserts (1..MAX_DEBT)
MAX_BURST, 4, max AUTO REFRESH commands per grant (1..MAX_DEBT)
PRE_EN, 1, 1 = issue PRECHARGE-ALL before the burst; 0 = skip
ADDR_W, 13, SDRAM address width (>=11)

Ports:
sclk  in  1  system clock
s_rst  in  1  asynchronous reset, active-high
flag_init_end  in  1  init done; interval counter runs only while high
ref_en  in  1  arbiter grant
ref_req  out  1  refresh request to arbiter
ref_urgent  out  1  debt >= URGENT_TH
flag_ref_end  out  1  one-cycle pulse: burst finished, bus returned
ref_busy  out  1  high while state != IDLE
ref_debt  out  4  current owed-refresh count
ref_overflow  out  1  sticky: tick arrived with debt == MAX_DEBT
aref_cmd  out  4  {cs_n,ras_n,cas_n,we_n}; NOP 0111, PRE 0010, AREF 0001
sdram_addr  out  ADDR_W  constant, bit 10 = 1 (precharge-all), other bits 0

Behaviour:
- Reset (s_rst high, async): state IDLE, interval count 0, debt 0, aref_cmd NOP, ref_req/ref_urgent/flag_ref_end/ref_busy/ref_overflow all 0.
- Interval counter:
  - Counts 0..T_REFI-1 while flag_init_end = 1, then wraps to 0.
  - Tick is the cycle where count == T_REFI-1.
  - flag_init_end = 0 freezes the count; debt is retained.
- Debt:
  - Tick adds +1, saturating at MAX_DEBT.
  - Each AREF issued subtracts 1.
  - Tick and AREF in the same cycle: debt unchanged.
  - Tick at MAX_DEBT with no AREF: debt stays, ref_overflow set.
- Outputs derived from registered debt/state:
  - ref_req = (state == IDLE) && debt > 0 && !flag_ref_end.
  - ref_urgent = debt >= URGENT_TH.
- Grant:
  - ref_en sampled high while ref_req is high accepts the request. At that edge, latch burst = min(debt, MAX_BURST) and leave IDLE.
  - ref_en at any other time is ignored.
  - ref_req drops the cycle after acceptance.
- State machine (aref_cmd registered, updated on the same edge as the state):
  - IDLE -> PRE (if PRE_EN) or AREF on grant.
  - PRE: aref_cmd = PRE for 1 cycle -> WAIT_RP.
  - WAIT_RP: NOP for T_RP-1 cycles (0 cycles if T_RP = 1) -> AREF.
  - AREF: aref_cmd = AREF for 1 cycle, debt-1, burst-1 -> WAIT_RFC.
  - WAIT_RFC: NOP for T_RFC-1 cycles; then AREF if burst > 0, else DONE.
  - DONE: flag_ref_end = 1 for 1 cycle, aref_cmd NOP -> IDLE.
- Ticks during a burst only add debt; burst length stays fixed at grant. Remaining debt re-raises ref_req the cycle after DONE.
- aref_cmd is NOP in every cycle not listed above.
- Reset mid-burst: immediate return to reset values; no partial command held.

Test Plan:
- Init gating: flag_init_end = 0 for 5000 cycles -> ref_req stays 0, ref_debt 0. Raise flag_init_end -> ref_req = 1 and ref_debt = 1 exactly T_REFI cycles later.
- Single refresh, defaults: debt 1, grant -> PRE on grant+1, NOPs, AREF on grant+3, NOPs grant+4..+9, flag_ref_end pulse on grant+10, ref_debt 0.
- Burst: withhold grant for 5 ticks -> ref_debt 5, ref_urgent 0. Grant -> 1 PRE + 4 AREFs spaced 7 cycles, then flag_ref_end. ref_debt 1 and ref_req high the cycle after DONE.
- Saturation/urgency: withhold grant for 9 ticks -> ref_urgent rises at debt 6, ref_debt holds 8, ref_overflow = 1 and stays set after the debt is serviced.
- Simultaneous tick and AREF: align a tick with the AREF cycle at debt 2 -> ref_debt remains 2 after that edge. PRE_EN = 0 build: first command after grant is AREF at grant+1.
- Async reset asserted during WAIT_RFC -> aref_cmd NOP, ref_debt 0 and ref_busy 0 immediately, without waiting for a clock edge.
